// File: rtl/cdc_fifo_pkg.sv
// Shared Gray/binary helpers and defaults for the dual-clock FIFO pointer logic.
// Functions work on a 32-bit container; zero-extended narrower pointers convert correctly.
package cdc_fifo_pkg;

  localparam int ADDR_W_DEF = 3;
  localparam int DEPTH      = 2**ADDR_W_DEF;
  localparam int CONV_W     = 32;

  function automatic logic [CONV_W-1:0] bin2gray(input logic [CONV_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down; leading zeros of a narrow pointer leave the result unchanged.
  function automatic logic [CONV_W-1:0] gray2bin(input logic [CONV_W-1:0] g);
    logic [CONV_W-1:0] b;
    b[CONV_W-1] = g[CONV_W-1];
    for (int i = CONV_W-2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_wr_ptr_ctrl_if.sv
// Write-side handshake bundle between the FIFO write port and its pointer controller.
interface fifo_wr_ptr_ctrl_if #(
  parameter int ADDR_W = 3
);
  logic              wr_en;
  logic [ADDR_W:0]   rgray_sync;
  logic              wpush;
  logic [ADDR_W-1:0] waddr;
  logic [ADDR_W:0]   wgray;
  logic              wfull;
  logic              walmost_full;
  logic [ADDR_W:0]   wlevel;
  logic              overflow;

  modport master (
    output wr_en, rgray_sync,
    input  wpush, waddr, wgray, wfull, walmost_full, wlevel, overflow
  );

  modport slave (
    input  wr_en, rgray_sync,
    output wpush, waddr, wgray, wfull, walmost_full, wlevel, overflow
  );
endinterface

// File: rtl/fifo_wr_ptr_ctrl.sv
// Write-domain pointer, level and full/almost-full flag controller for the dual-clock FIFO.
// Flags are computed from the post-write pointer so the filling write raises wfull on its own edge.
module fifo_wr_ptr_ctrl
  import cdc_fifo_pkg::*;
#(
  parameter int ADDR_W    = 3,
  parameter int AF_THRESH = 6
) (
  input  logic               clk,
  input  logic               rst,
  fifo_wr_ptr_ctrl_if.slave  wif
);

  localparam int PW = ADDR_W + 1;
  localparam logic [ADDR_W:0] AF_LVL = PW'(AF_THRESH);

  logic [ADDR_W:0] wbin_q,  wbin_d;
  logic [ADDR_W:0] wgray_q, wgray_d;
  logic [ADDR_W:0] level_q, level_d;
  logic            wfull_q, wfull_d;
  logic            waf_q,   waf_d;
  logic            ovf_q,   ovf_d;
  logic            wpush;
  logic [ADDR_W:0] rbin;
  logic [ADDR_W:0] rgray_full;

  always_comb begin
    wpush      = wif.wr_en & ~wfull_q;
    wbin_d     = wbin_q + PW'(wpush);
    wgray_d    = PW'(bin2gray(CONV_W'(wbin_d)));
    rbin       = PW'(gray2bin(CONV_W'(wif.rgray_sync)));
    level_d    = wbin_d - rbin;
    // Reader's Gray pointer with the top two bits inverted is where the writer sits when full.
    rgray_full = {~wif.rgray_sync[ADDR_W:ADDR_W-1], wif.rgray_sync[ADDR_W-2:0]};
    wfull_d    = (wgray_d == rgray_full);
    waf_d      = (level_d >= AF_LVL);
    ovf_d      = ovf_q | (wif.wr_en & wfull_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      level_q <= '0;
      wfull_q <= 1'b0;
      waf_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      level_q <= level_d;
      wfull_q <= wfull_d;
      waf_q   <= waf_d;
      ovf_q   <= ovf_d;
    end
  end

  assign wif.wpush        = wpush;
  assign wif.waddr        = wbin_q[ADDR_W-1:0];
  assign wif.wgray        = wgray_q;
  assign wif.wfull        = wfull_q;
  assign wif.walmost_full = waf_q;
  assign wif.wlevel       = level_q;
  assign wif.overflow     = ovf_q;

endmodule

// File: tb/tb_fifo_wr_ptr_ctrl.sv
// Bench for fifo_wr_ptr_ctrl (ADDR_W=3, AF_THRESH=6): directed vector table, then a reference model.
module tb_fifo_wr_ptr_ctrl;

  localparam int AW = 3;

  typedef struct {
    logic       chk_wpush;
    logic       wpush;
    logic [2:0] waddr;
    logic [3:0] wgray;
    logic       wfull;
    logic       waf;
    logic [3:0] wlevel;
    logic       ovf;
  } exp_t;

  typedef struct {
    logic       rst;
    logic       wr_en;
    logic [3:0] rbin;
    exp_t       e;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  fifo_wr_ptr_ctrl_if #(.ADDR_W(AW)) wif ();

  fifo_wr_ptr_ctrl #(.ADDR_W(AW), .AF_THRESH(6)) dut (
    .clk (clk),
    .rst (rst),
    .wif (wif)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle, check wpush before the edge, compare registered outputs after it.
  task automatic apply(input logic r, input logic we, input logic [3:0] rb, input exp_t e);
    exp_t x;
    @(negedge clk);
    rst = r;
    wif.wr_en = we;
    wif.rgray_sync = rb ^ (rb >> 1);
    exp_q.push_back(e);
    #1;
    if (e.chk_wpush) check("wpush", 32'(wif.wpush), 32'(e.wpush));
    @(posedge clk);
    #1;
    x = exp_q.pop_front();
    check("waddr",        32'(wif.waddr),        32'(x.waddr));
    check("wgray",        32'(wif.wgray),        32'(x.wgray));
    check("wfull",        32'(wif.wfull),        32'(x.wfull));
    check("walmost_full", 32'(wif.walmost_full), 32'(x.waf));
    check("wlevel",       32'(wif.wlevel),       32'(x.wlevel));
    check("overflow",     32'(wif.overflow),     32'(x.ovf));
  endtask

  // Independent model state: pointer held as a plain 4-bit counter.
  logic [3:0] m_wbin;
  logic       m_full;
  logic       m_ovf;

  task automatic model_step(input logic we, input logic [3:0] rb);
    exp_t e;
    logic push;
    logic [3:0] lvl;
    push   = we & ~m_full;
    m_ovf  = m_ovf | (we & m_full);
    m_wbin = m_wbin + {3'b000, push};
    lvl    = m_wbin - rb;
    e.chk_wpush = 1'b1;
    e.wpush  = push;
    e.waddr  = m_wbin[2:0];
    e.wgray  = m_wbin ^ (m_wbin >> 1);
    e.wfull  = (lvl == 4'd8);
    e.waf    = (lvl >= 4'd6);
    e.wlevel = lvl;
    e.ovf    = m_ovf;
    apply(1'b0, we, rb, e);
    m_full = e.wfull;
  endtask

  vec_t vt[$];

  function automatic vec_t mk(logic r, logic we, logic [3:0] rb, logic cw, logic wp,
                              logic [2:0] wa, logic [3:0] wg, logic wf, logic af,
                              logic [3:0] lv, logic ov);
    vec_t v;
    v.rst = r; v.wr_en = we; v.rbin = rb;
    v.e.chk_wpush = cw; v.e.wpush = wp; v.e.waddr = wa; v.e.wgray = wg;
    v.e.wfull = wf; v.e.waf = af; v.e.wlevel = lv; v.e.ovf = ov;
    return v;
  endfunction

  initial begin
    logic [3:0] rb;
    wif.wr_en = 1'b0;
    wif.rgray_sync = '0;

    // Reset with wr_en high: pointers stay 0 even though wpush=1.
    vt.push_back(mk(1, 1, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0));
    vt.push_back(mk(1, 1, 0, 1, 1, 0, 4'h0, 0, 0, 0, 0));
    // Fill eight entries.
    vt.push_back(mk(0, 1, 0, 1, 1, 1, 4'h1, 0, 0, 1, 0));
    vt.push_back(mk(0, 1, 0, 1, 1, 2, 4'h3, 0, 0, 2, 0));
    vt.push_back(mk(0, 1, 0, 1, 1, 3, 4'h2, 0, 0, 3, 0));
    vt.push_back(mk(0, 1, 0, 1, 1, 4, 4'h6, 0, 0, 4, 0));
    vt.push_back(mk(0, 1, 0, 1, 1, 5, 4'h7, 0, 0, 5, 0));
    vt.push_back(mk(0, 1, 0, 1, 1, 6, 4'h5, 0, 1, 6, 0));
    vt.push_back(mk(0, 1, 0, 1, 1, 7, 4'h4, 0, 1, 7, 0));
    vt.push_back(mk(0, 1, 0, 1, 1, 0, 4'hC, 1, 1, 8, 0));
    // Writes while full are refused; overflow sticks.
    vt.push_back(mk(0, 1, 0, 1, 0, 0, 4'hC, 1, 1, 8, 1));
    vt.push_back(mk(0, 1, 0, 1, 0, 0, 4'hC, 1, 1, 8, 1));
    // Reader advances to 1: release, then one push refills.
    vt.push_back(mk(0, 0, 1, 1, 0, 0, 4'hC, 0, 1, 7, 1));
    vt.push_back(mk(0, 1, 1, 1, 1, 1, 4'hD, 1, 1, 8, 1));
    // Reader advance and write together while full: write refused, level drops.
    vt.push_back(mk(0, 1, 2, 1, 0, 1, 4'hD, 0, 1, 7, 1));
    vt.push_back(mk(0, 1, 2, 1, 1, 2, 4'hF, 1, 1, 8, 1));
    // Drain to level 5, then reset mid-operation with wr_en high.
    vt.push_back(mk(0, 0, 5, 1, 0, 2, 4'hF, 0, 0, 5, 1));
    vt.push_back(mk(1, 1, 5, 1, 1, 0, 4'h0, 0, 0, 0, 0));

    foreach (vt[i]) apply(vt[i].rst, vt[i].wr_en, vt[i].rbin, vt[i].e);

    m_wbin = '0;
    m_full = 1'b0;
    m_ovf  = 1'b0;

    // Reader follows the writer: 20 accepted pushes wrap the 4-bit pointer.
    for (int i = 0; i < 20; i++) begin
      model_step(1'b1, m_wbin);
      if (i == 15) check("wrap_wgray", 32'(wif.wgray), 32'd0);
    end

    // Random writes with a lagging reader, reaching full and overflow along the way.
    rb = m_wbin;
    for (int i = 0; i < 80; i++) begin
      if (rb != m_wbin && $urandom_range(0, 2) == 0) rb = rb + 4'd1;
      model_step(1'($urandom_range(0, 3) != 0), rb);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
